// File: rtl/regbank_param.sv
// Parametrised 2R/1W register file with byte-enable writes, registered reads with
// write-to-read bypass and a clear sequencer. Define ZERO_REG_EN to hardwire register 0 to zero.
module regbank_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     dr,
    input  logic [DATA_W-1:0]     wrData,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [ADDR_W-1:0]     sr1,
    input  logic [ADDR_W-1:0]     sr2,
    input  logic                  rden1,
    input  logic                  rden2,
    output logic [DATA_W-1:0]     rdData1,
    output logic [DATA_W-1:0]     rdData2,
    input  logic                  clr,
    output logic                  busy,
    output logic                  wr_drop
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_regs [DEPTH];
    logic [ADDR_W-1:0]   r_ptr;
    logic [DATA_W-1:0]   r_rd1;
    logic [DATA_W-1:0]   r_rd2;
    logic                r_wr_drop;

    logic                w_accept;
    logic                w_wr_en;
    logic [DATA_W-1:0]   w_old;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_rd1_nxt;
    logic [DATA_W-1:0]   w_rd2_nxt;

    assign busy     = (r_state == S_CLEAR);
    assign w_accept = write && !busy;
`ifdef ZERO_REG_EN
    // Writes to register 0 are accepted (no wr_drop) but never land in storage.
    assign w_wr_en  = w_accept && (dr != '0);
`else
    assign w_wr_en  = w_accept;
`endif

    assign w_old = r_regs[dr];

    always_comb begin
        w_merged = w_old;
        for (int b = 0; b < NBYTES; b++) begin
            if (wr_be[b]) w_merged[8*b +: 8] = wrData[8*b +: 8];
        end
    end

    // Read priority: register being swept this edge, then same-edge write, then storage.
    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] sr);
        if (busy && (sr == r_ptr))      return '0;
        if (w_wr_en && (sr == dr))      return w_merged;
        return r_regs[sr];
    endfunction

    always_comb begin
        w_rd1_nxt = f_read(sr1);
        w_rd2_nxt = f_read(sr2);
    end

    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr) w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_ptr == ADDR_W'(DEPTH - 1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= busy ? r_ptr + ADDR_W'(1) : '0;
            r_wr_drop <= write && busy;
            if (rden1) r_rd1 <= w_rd1_nxt;
            if (rden2) r_rd2 <= w_rd2_nxt;
        end
    end

    // NOTE: the array is reset because reset must zero every register; this keeps it in flops, not RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (busy) begin
            r_regs[r_ptr] <= '0;
        end else if (w_wr_en) begin
            r_regs[dr] <= w_merged;
        end
    end

    assign rdData1 = r_rd1;
    assign rdData2 = r_rd2;
    assign wr_drop = r_wr_drop;
endmodule

// File: tb/tb_regbank_param.sv
// Directed self-checking bench for regbank_param (DATA_W=32, ADDR_W=2), default build.
module tb_regbank_param;
    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic [1:0]  dr;
    logic [31:0] wrData;
    logic [3:0]  wr_be;
    logic [1:0]  sr1, sr2;
    logic        rden1, rden2;
    logic [31:0] rdData1, rdData2;
    logic        clr;
    logic        busy;
    logic        wr_drop;

    int n_assert = 0;
    int n_fail   = 0;

    regbank_param #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .write(write), .dr(dr), .wrData(wrData), .wr_be(wr_be),
        .sr1(sr1), .sr2(sr2), .rden1(rden1), .rden2(rden2),
        .rdData1(rdData1), .rdData2(rdData2), .clr(clr), .busy(busy), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        write = 1'b1; dr = a; wrData = d; wr_be = be;
        tick();
        write = 1'b0;
    endtask

    task automatic rd2(input logic [1:0] a1, input logic [1:0] a2,
                       input logic [31:0] e1, input logic [31:0] e2, input string tag);
        sr1 = a1; sr2 = a2; rden1 = 1'b1; rden2 = 1'b1;
        tick();
        check({tag, "_rd1"}, rdData1, e1);
        check({tag, "_rd2"}, rdData2, e2);
        rden1 = 1'b0; rden2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; dr = '0; wrData = '0; wr_be = '0;
        sr1 = '0; sr2 = '0; rden1 = 1'b0; rden2 = 1'b0; clr = 1'b0;
        tick();
        tick();
        check("reset_rd1", rdData1, 32'h0);
        check("reset_rd2", rdData2, 32'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_drop", wr_drop, 1'b0);
        rst = 1'b0;

        // Fill and read
        for (int i = 0; i < 4; i++) wr(2'(i), 32'(5 * i), 4'hF);
        check("fill_drop", wr_drop, 1'b0);
        rd2(2'd0, 2'd1, 32'd0,  32'd5,  "fill0");
        rd2(2'd1, 2'd2, 32'd5,  32'd10, "fill1");
        rd2(2'd2, 2'd3, 32'd10, 32'd15, "fill2");
        rd2(2'd3, 2'd0, 32'd15, 32'd0,  "fill3");

        // Byte enables and read-enable hold
        wr(2'd2, 32'h11223344, 4'hF);
        wr(2'd2, 32'hAABBCCDD, 4'b0101);
        rd2(2'd2, 2'd2, 32'h11BB33DD, 32'h11BB33DD, "byte_en");
        sr1 = 2'd0; sr2 = 2'd3;
        tick();
        check("hold_rd1", rdData1, 32'h11BB33DD);
        check("hold_rd2", rdData2, 32'h11BB33DD);
        wr(2'd2, 32'h0, 4'h0);
        rd2(2'd2, 2'd2, 32'h11BB33DD, 32'h11BB33DD, "be_zero");

        // Full bypass on both ports
        write = 1'b1; dr = 2'd1; wrData = 32'hDEADBEEF; wr_be = 4'hF;
        sr1 = 2'd1; sr2 = 2'd1; rden1 = 1'b1; rden2 = 1'b1;
        tick();
        check("bypass_rd1", rdData1, 32'hDEADBEEF);
        check("bypass_rd2", rdData2, 32'hDEADBEEF);
        write = 1'b0; rden1 = 1'b0; rden2 = 1'b0;

        // Partial bypass
        wr(2'd1, 32'h12345678, 4'hF);
        write = 1'b1; dr = 2'd1; wrData = 32'hDEADBEEF; wr_be = 4'b0011;
        sr1 = 2'd1; rden1 = 1'b1;
        tick();
        check("pbypass_rd1", rdData1, 32'h1234BEEF);
        write = 1'b0; rden1 = 1'b0;
        rd2(2'd0, 2'd1, 32'h0, 32'h1234BEEF, "pbypass_after");

        // Clear sweep with writes held to dr=3
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("sweep_busy0", busy, 1'b1);
        write = 1'b1; dr = 2'd3; wrData = 32'h77; wr_be = 4'hF;
        for (int j = 1; j <= 4; j++) begin
            clr = (j == 2);
            tick();
            check($sformatf("sweep_busy%0d", j), busy, (j < 4) ? 1'b1 : 1'b0);
            check($sformatf("sweep_drop%0d", j), wr_drop, 1'b1);
        end
        clr = 1'b0;
        tick();
        write = 1'b0;
        check("post_sweep_drop", wr_drop, 1'b0);
        check("post_sweep_busy", busy, 1'b0);
        rd2(2'd0, 2'd1, 32'h0, 32'h0,  "sweep_rd01");
        rd2(2'd2, 2'd3, 32'h0, 32'h77, "sweep_rd23");

        // Clear and write on the same IDLE edge, reads during the sweep
        wr(2'd2, 32'h22, 4'hF);
        clr = 1'b1; write = 1'b1; dr = 2'd3; wrData = 32'h55; wr_be = 4'hF;
        tick();
        clr = 1'b0; write = 1'b0;
        check("cw_drop", wr_drop, 1'b0);
        rd2(2'd3, 2'd2, 32'h55, 32'h22, "cw_k1");
        rd2(2'd3, 2'd2, 32'h55, 32'h22, "cw_k2");
        rd2(2'd3, 2'd2, 32'h55, 32'h0,  "cw_k3");
        rd2(2'd3, 2'd2, 32'h0,  32'h0,  "cw_k4");
        check("cw_busy", busy, 1'b0);
        rd2(2'd3, 2'd2, 32'h0,  32'h0,  "cw_after");

        // Reset mid-sweep
        wr(2'd1, 32'h1111, 4'hF);
        wr(2'd3, 32'h3333, 4'hF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tick();
        check("mid_busy", busy, 1'b1);
        rst = 1'b1; sr1 = 2'd3; sr2 = 2'd3; rden1 = 1'b1; rden2 = 1'b1;
        tick();
        rst = 1'b0; rden1 = 1'b0; rden2 = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_rd1", rdData1, 32'h0);
        check("rst_rd2", rdData2, 32'h0);
        check("rst_drop", wr_drop, 1'b0);
        wr(2'd1, 32'h99, 4'hF);
        check("rst_wr_drop", wr_drop, 1'b0);
        rd2(2'd0, 2'd1, 32'h0, 32'h99, "rst_rd01");
        rd2(2'd2, 2'd3, 32'h0, 32'h0,  "rst_rd23");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
